// File: rtl/store_buffer.sv
// store_buffer
// Write side of the MEM stage. Stores from EX are aligned into byte lanes
// and given byte enables, then held in an in-order buffer. The buffer drains
// to the data bus one entry at a time over a req/ack handshake. The pipeline
// only has to stall when the buffer is full.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   st_valid_i        store request from EX
//   st_addr_i         store byte address
//   st_data_i         store data, source in the low bits
//   st_mask_i         size code (0001 byte, 0011 half, 1111 word; bit4 ignored)
//   flush_i           discard this cycle's incoming store
//   st_ready_o        buffer has a free entry
//   st_misalign_o     incoming store is misaligned or has an illegal size
//   dbus_req_o        write request valid
//   dbus_addr_o       word-aligned write address
//   dbus_wdata_o      lane-aligned write data
//   dbus_be_o         byte enables
//   dbus_ack_i        bus accepts the current request
//   ld_addr_i         address of the load in EX/MEM
//   ld_hit_o          load word matches a buffered store
//   sb_empty_o        nothing buffered and no request outstanding
module store_buffer #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            st_valid_i,
    input  logic [XLEN-1:0] st_addr_i,
    input  logic [XLEN-1:0] st_data_i,
    input  logic [4:0]      st_mask_i,
    input  logic            flush_i,
    output logic            st_ready_o,
    output logic            st_misalign_o,
    output logic            dbus_req_o,
    output logic [XLEN-1:0] dbus_addr_o,
    output logic [XLEN-1:0] dbus_wdata_o,
    output logic [3:0]      dbus_be_o,
    input  logic            dbus_ack_i,
    input  logic [XLEN-1:0] ld_addr_i,
    output logic            ld_hit_o,
    output logic            sb_empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {IDLE, REQ} state_t;

    state_t          state, state_next;
    logic [XLEN-1:0] entry_addr [DEPTH];
    logic [XLEN-1:0] entry_data [DEPTH];
    logic [3:0]      entry_be   [DEPTH];
    logic [PTR_W-1:0] head_ptr, tail_ptr;
    logic [CNT_W-1:0] count, count_next;

    logic            is_byte, is_half, is_word;
    logic            accept, pop;
    logic [XLEN-1:0] aligned_data;
    logic [3:0]      aligned_be;
    logic [PTR_W-1:0] slot_offset;

    // Bit 4 of the size code and the byte offset of the load address carry
    // no information here.
    logic unused_bits;
    assign unused_bits = &{1'b0, st_mask_i[4], ld_addr_i[1:0]};

    // Size decode and misalignment check on the incoming store.
    assign is_byte = (st_mask_i[3:0] == 4'b0001);
    assign is_half = (st_mask_i[3:0] == 4'b0011);
    assign is_word = (st_mask_i[3:0] == 4'b1111);

    assign st_misalign_o = st_valid_i &
                           ((is_half & st_addr_i[0]) |
                            (is_word & (st_addr_i[1:0] != 2'b00)) |
                            ~(is_byte | is_half | is_word));

    // Space is judged on the registered count, so a same-cycle pop never
    // frees a slot for the store arriving in that cycle.
    assign st_ready_o = (count < CNT_W'(DEPTH));
    assign accept     = st_valid_i & st_ready_o & ~st_misalign_o & ~flush_i;
    assign pop        = (state == REQ) & dbus_ack_i;
    assign count_next = count + CNT_W'(accept) - CNT_W'(pop);

    // Replicate the source into every lane so the enables alone select
    // which bytes the bus writes.
    always_comb begin
        aligned_data = st_data_i;
        aligned_be   = 4'b1111;
        if (is_byte) begin
            aligned_data = {4{st_data_i[7:0]}};
            aligned_be   = 4'b0001 << st_addr_i[1:0];
        end else if (is_half) begin
            aligned_data = {2{st_data_i[15:0]}};
            aligned_be   = 4'b0011 << {st_addr_i[1], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            head_ptr <= '0;
            tail_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_addr[i] <= '0;
                entry_data[i] <= '0;
                entry_be[i]   <= '0;
            end
        end else begin
            state <= state_next;
            count <= count_next;
            if (accept) begin
                entry_addr[tail_ptr] <= {st_addr_i[XLEN-1:2], 2'b00};
                entry_data[tail_ptr] <= aligned_data;
                entry_be[tail_ptr]   <= aligned_be;
                tail_ptr             <= tail_ptr + 1'b1;
            end
            if (pop) begin
                head_ptr <= head_ptr + 1'b1;
            end
        end
    end

    // REQ is held for as long as anything remains after the edge, which is
    // what gives back-to-back drains at one store per cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (count_next != '0) state_next = REQ;
            REQ:     if (count_next == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign dbus_req_o   = (state == REQ);
    assign dbus_addr_o  = entry_addr[head_ptr];
    assign dbus_wdata_o = entry_data[head_ptr];
    assign dbus_be_o    = entry_be[head_ptr];
    assign sb_empty_o   = (count == '0) & (state == IDLE);

    // A slot is live when its distance from the head is below the count;
    // the head being acked this cycle still counts.
    always_comb begin
        ld_hit_o    = 1'b0;
        slot_offset = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_offset = PTR_W'(i) - head_ptr;
            if (({1'b0, slot_offset} < count) &&
                (entry_addr[i][XLEN-1:2] == ld_addr_i[XLEN-1:2])) begin
                ld_hit_o = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Testbench for store_buffer. Directed scenarios check the headline
// behaviours against fixed values; a randomized run compares every output
// each cycle against a queue-based model of the buffer.
module tb_store_buffer;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        st_valid_i;
    logic [31:0] st_addr_i;
    logic [31:0] st_data_i;
    logic [4:0]  st_mask_i;
    logic        flush_i;
    logic        st_ready_o;
    logic        st_misalign_o;
    logic        dbus_req_o;
    logic [31:0] dbus_addr_o;
    logic [31:0] dbus_wdata_o;
    logic [3:0]  dbus_be_o;
    logic        dbus_ack_i;
    logic [31:0] ld_addr_i;
    logic        ld_hit_o;
    logic        sb_empty_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } entry_t;

    entry_t q[$];

    store_buffer #(.XLEN(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .st_valid_i(st_valid_i), .st_addr_i(st_addr_i), .st_data_i(st_data_i),
        .st_mask_i(st_mask_i), .flush_i(flush_i),
        .st_ready_o(st_ready_o), .st_misalign_o(st_misalign_o),
        .dbus_req_o(dbus_req_o), .dbus_addr_o(dbus_addr_o),
        .dbus_wdata_o(dbus_wdata_o), .dbus_be_o(dbus_be_o),
        .dbus_ack_i(dbus_ack_i), .ld_addr_i(ld_addr_i),
        .ld_hit_o(ld_hit_o), .sb_empty_o(sb_empty_o)
    );

    always #5 clk = ~clk;

    // Reference model: the buffer is a queue of already-aligned entries.
    function automatic entry_t make_entry(logic [31:0] a, logic [31:0] d, logic [4:0] m);
        entry_t e;
        int k;
        k = int'(a % 4);
        e.addr = a - (a % 4);
        case (m[3:0])
            4'b0001: begin e.data = (d % 256) * 32'h0101_0101;   e.be = 4'(1 << k); end
            4'b0011: begin e.data = (d % 65536) * 32'h0001_0001; e.be = 4'(3 << ((k / 2) * 2)); end
            default: begin e.data = d;                           e.be = 4'hF; end
        endcase
        return e;
    endfunction

    function automatic bit exp_misalign(logic v, logic [31:0] a, logic [4:0] m);
        if (!v) return 1'b0;
        case (m[3:0])
            4'b0001: return 1'b0;
            4'b0011: return (a % 2) != 0;
            4'b1111: return (a % 4) != 0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic bit exp_hit(logic [31:0] la);
        foreach (q[i]) if ((q[i].addr / 4) == (la / 4)) return 1'b1;
        return 1'b0;
    endfunction

    // Advance one clock with the current inputs and update the model.
    // The bus is requesting exactly when the model queue is non-empty.
    task automatic step();
        bit acc, pp;
        acc = st_valid_i && (q.size() < DEPTH) && !flush_i &&
              !exp_misalign(st_valid_i, st_addr_i, st_mask_i);
        pp  = (q.size() > 0) && dbus_ack_i;
        @(posedge clk);
        if (rst) q.delete();
        else begin
            if (pp) void'(q.pop_front());
            if (acc) q.push_back(make_entry(st_addr_i, st_data_i, st_mask_i));
        end
        #1;
    endtask

    task automatic clear_inputs();
        st_valid_i = 1'b0; st_addr_i = '0; st_data_i = '0; st_mask_i = '0;
        flush_i = 1'b0; dbus_ack_i = 1'b0; ld_addr_i = '0;
    endtask

    task automatic set_store(logic [31:0] a, logic [31:0] d, logic [4:0] m);
        st_valid_i = 1'b1; st_addr_i = a; st_data_i = d; st_mask_i = m;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        step(); step();
        total++; if (dbus_req_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_req got=%b want=0", dbus_req_o); end
        total++; if (dbus_addr_o !== 32'h0) begin bad++; $display("[TB] FAIL reset_addr got=%h want=0", dbus_addr_o); end
        total++; if (dbus_wdata_o !== 32'h0) begin bad++; $display("[TB] FAIL reset_wdata got=%h want=0", dbus_wdata_o); end
        total++; if (dbus_be_o !== 4'h0) begin bad++; $display("[TB] FAIL reset_be got=%b want=0000", dbus_be_o); end
        total++; if (st_ready_o !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready got=%b want=1", st_ready_o); end
        total++; if (sb_empty_o !== 1'b1) begin bad++; $display("[TB] FAIL reset_empty got=%b want=1", sb_empty_o); end
        total++; if (ld_hit_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_hit got=%b want=0", ld_hit_o); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_byte_store();
        set_store(32'h0000_1003, 32'h1122_33A5, 5'b00001);
        #1;
        total++; if (st_misalign_o !== 1'b0) begin bad++; $display("[TB] FAIL sb_misalign got=%b want=0", st_misalign_o); end
        step();
        st_valid_i = 1'b0;
        #1;
        total++; if (dbus_req_o !== 1'b1) begin bad++; $display("[TB] FAIL sb_req got=%b want=1", dbus_req_o); end
        total++; if (dbus_addr_o !== 32'h0000_1000) begin bad++; $display("[TB] FAIL sb_addr got=%h want=00001000", dbus_addr_o); end
        total++; if (dbus_wdata_o !== 32'hA5A5_A5A5) begin bad++; $display("[TB] FAIL sb_wdata got=%h want=a5a5a5a5", dbus_wdata_o); end
        total++; if (dbus_be_o !== 4'b1000) begin bad++; $display("[TB] FAIL sb_be got=%b want=1000", dbus_be_o); end
        total++; if (sb_empty_o !== 1'b0) begin bad++; $display("[TB] FAIL sb_busy got=%b want=0", sb_empty_o); end
        dbus_ack_i = 1'b1;
        step();
        dbus_ack_i = 1'b0;
        #1;
        total++; if (sb_empty_o !== 1'b1) begin bad++; $display("[TB] FAIL sb_drained got=%b want=1", sb_empty_o); end
        total++; if (dbus_req_o !== 1'b0) begin bad++; $display("[TB] FAIL sb_req_drop got=%b want=0", dbus_req_o); end
    endtask

    task automatic test_half_and_misalign();
        set_store(32'h0000_2002, 32'h1234_BEEF, 5'b00011);
        step();
        st_valid_i = 1'b0;
        #1;
        total++; if (dbus_addr_o !== 32'h0000_2000) begin bad++; $display("[TB] FAIL sh_addr got=%h want=00002000", dbus_addr_o); end
        total++; if (dbus_wdata_o !== 32'hBEEF_BEEF) begin bad++; $display("[TB] FAIL sh_wdata got=%h want=beefbeef", dbus_wdata_o); end
        total++; if (dbus_be_o !== 4'b1100) begin bad++; $display("[TB] FAIL sh_be got=%b want=1100", dbus_be_o); end
        dbus_ack_i = 1'b1;
        step();
        dbus_ack_i = 1'b0;
        set_store(32'h0000_3001, 32'hDEAD_0001, 5'b01111);
        #1;
        total++; if (st_misalign_o !== 1'b1) begin bad++; $display("[TB] FAIL sw_misalign got=%b want=1", st_misalign_o); end
        step();
        st_valid_i = 1'b0;
        #1;
        total++; if (dbus_req_o !== 1'b0) begin bad++; $display("[TB] FAIL sw_misalign_req got=%b want=0", dbus_req_o); end
        total++; if (sb_empty_o !== 1'b1) begin bad++; $display("[TB] FAIL sw_misalign_empty got=%b want=1", sb_empty_o); end
    endtask

    task automatic test_back_to_back();
        set_store(32'h10, 32'hAAAA_AAAA, 5'b01111);
        step();
        set_store(32'h14, 32'hBBBB_BBBB, 5'b01111);
        step();
        set_store(32'h18, 32'hCCCC_CCCC, 5'b01111);
        #1;
        total++; if (st_ready_o !== 1'b0) begin bad++; $display("[TB] FAIL full_ready got=%b want=0", st_ready_o); end
        step();
        #1;
        total++; if (dbus_addr_o !== 32'h10) begin bad++; $display("[TB] FAIL full_refuse_head got=%h want=00000010", dbus_addr_o); end
        total++; if (q.size() != 2) begin bad++; $display("[TB] FAIL full_model_size got=%0d want=2", q.size()); end
        dbus_ack_i = 1'b1;
        step();
        total++; if (dbus_req_o !== 1'b1) begin bad++; $display("[TB] FAIL b2b_req1 got=%b want=1", dbus_req_o); end
        total++; if (dbus_addr_o !== 32'h14) begin bad++; $display("[TB] FAIL b2b_addr1 got=%h want=00000014", dbus_addr_o); end
        total++; if (dbus_wdata_o !== 32'hBBBB_BBBB) begin bad++; $display("[TB] FAIL b2b_wdata1 got=%h want=bbbbbbbb", dbus_wdata_o); end
        total++; if (st_ready_o !== 1'b1) begin bad++; $display("[TB] FAIL b2b_ready got=%b want=1", st_ready_o); end
        step();
        st_valid_i = 1'b0;
        #1;
        total++; if (dbus_req_o !== 1'b1) begin bad++; $display("[TB] FAIL b2b_req2 got=%b want=1", dbus_req_o); end
        total++; if (dbus_addr_o !== 32'h18) begin bad++; $display("[TB] FAIL b2b_addr2 got=%h want=00000018", dbus_addr_o); end
        total++; if (dbus_wdata_o !== 32'hCCCC_CCCC) begin bad++; $display("[TB] FAIL b2b_wdata2 got=%h want=cccccccc", dbus_wdata_o); end
        step();
        dbus_ack_i = 1'b0;
        #1;
        total++; if (sb_empty_o !== 1'b1) begin bad++; $display("[TB] FAIL b2b_empty got=%b want=1", sb_empty_o); end
    endtask

    task automatic test_ld_hit();
        set_store(32'h40, 32'h0404_0404, 5'b01111);
        step();
        st_valid_i = 1'b0;
        ld_addr_i = 32'h42;
        #1;
        total++; if (ld_hit_o !== 1'b1) begin bad++; $display("[TB] FAIL hit_same_word got=%b want=1", ld_hit_o); end
        ld_addr_i = 32'h44;
        #1;
        total++; if (ld_hit_o !== 1'b0) begin bad++; $display("[TB] FAIL hit_next_word got=%b want=0", ld_hit_o); end
        ld_addr_i = 32'h42;
        dbus_ack_i = 1'b1;
        #1;
        total++; if (ld_hit_o !== 1'b1) begin bad++; $display("[TB] FAIL hit_during_ack got=%b want=1", ld_hit_o); end
        step();
        dbus_ack_i = 1'b0;
        #1;
        total++; if (ld_hit_o !== 1'b0) begin bad++; $display("[TB] FAIL hit_after_drain got=%b want=0", ld_hit_o); end
        ld_addr_i = '0;
    endtask

    task automatic test_flush_illegal();
        set_store(32'h50, 32'h5555_5555, 5'b01111);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        st_valid_i = 1'b0;
        #1;
        total++; if (sb_empty_o !== 1'b1) begin bad++; $display("[TB] FAIL flush_empty got=%b want=1", sb_empty_o); end
        total++; if (dbus_req_o !== 1'b0) begin bad++; $display("[TB] FAIL flush_req got=%b want=0", dbus_req_o); end
        set_store(32'h60, 32'h6666_6666, 5'b00111);
        #1;
        total++; if (st_misalign_o !== 1'b1) begin bad++; $display("[TB] FAIL illegal_size got=%b want=1", st_misalign_o); end
        st_valid_i = 1'b0;
        #1;
        total++; if (st_misalign_o !== 1'b0) begin bad++; $display("[TB] FAIL illegal_novalid got=%b want=0", st_misalign_o); end
        set_store(32'h64, 32'h7777_7777, 5'b11111);
        #1;
        total++; if (st_misalign_o !== 1'b0) begin bad++; $display("[TB] FAIL bit4_ignored got=%b want=0", st_misalign_o); end
        step();
        st_valid_i = 1'b0;
        #1;
        total++; if (dbus_req_o !== 1'b1) begin bad++; $display("[TB] FAIL bit4_queued got=%b want=1", dbus_req_o); end
        dbus_ack_i = 1'b1;
        step();
        dbus_ack_i = 1'b0;
    endtask

    task automatic test_reset_mid_request();
        set_store(32'h80, 32'h8888_8888, 5'b01111);
        step();
        set_store(32'h84, 32'h9999_9999, 5'b01111);
        step();
        st_valid_i = 1'b0;
        #1;
        total++; if (st_ready_o !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_full got=%b want=0", st_ready_o); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        total++; if (dbus_req_o !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_req got=%b want=0", dbus_req_o); end
        total++; if (st_ready_o !== 1'b1) begin bad++; $display("[TB] FAIL rstmid_ready got=%b want=1", st_ready_o); end
        total++; if (sb_empty_o !== 1'b1) begin bad++; $display("[TB] FAIL rstmid_empty got=%b want=1", sb_empty_o); end
    endtask

    task automatic test_random();
        logic [4:0] masks [4];
        masks[0] = 5'b00001; masks[1] = 5'b00011; masks[2] = 5'b01111; masks[3] = 5'b10101;
        for (int cyc = 0; cyc < 400; cyc++) begin
            st_valid_i = ($urandom_range(0, 9) < 7);
            st_addr_i  = 32'h100 + $urandom_range(0, 31);
            st_data_i  = $urandom;
            st_mask_i  = masks[$urandom_range(0, 3)];
            flush_i    = ($urandom_range(0, 9) == 0);
            dbus_ack_i = $urandom_range(0, 1);
            ld_addr_i  = 32'h100 + $urandom_range(0, 31);
            #1;
            total++; if (st_ready_o !== (q.size() < DEPTH)) begin bad++; $display("[TB] FAIL rnd_ready cyc=%0d got=%b want=%b", cyc, st_ready_o, q.size() < DEPTH); end
            total++; if (st_misalign_o !== exp_misalign(st_valid_i, st_addr_i, st_mask_i)) begin bad++; $display("[TB] FAIL rnd_misalign cyc=%0d got=%b addr=%h mask=%b", cyc, st_misalign_o, st_addr_i, st_mask_i); end
            total++; if (dbus_req_o !== (q.size() != 0)) begin bad++; $display("[TB] FAIL rnd_req cyc=%0d got=%b want=%b", cyc, dbus_req_o, q.size() != 0); end
            total++; if (sb_empty_o !== (q.size() == 0)) begin bad++; $display("[TB] FAIL rnd_empty cyc=%0d got=%b want=%b", cyc, sb_empty_o, q.size() == 0); end
            total++; if (ld_hit_o !== exp_hit(ld_addr_i)) begin bad++; $display("[TB] FAIL rnd_hit cyc=%0d got=%b want=%b", cyc, ld_hit_o, exp_hit(ld_addr_i)); end
            if (q.size() != 0) begin
                total++;
                if (dbus_addr_o !== q[0].addr || dbus_wdata_o !== q[0].data || dbus_be_o !== q[0].be) begin
                    bad++;
                    $display("[TB] FAIL rnd_head cyc=%0d got=%h/%h/%b want=%h/%h/%b", cyc,
                             dbus_addr_o, dbus_wdata_o, dbus_be_o, q[0].addr, q[0].data, q[0].be);
                end
            end
            step();
        end
        clear_inputs();
        dbus_ack_i = 1'b1;
        step(); step(); step();
        dbus_ack_i = 1'b0;
        #1;
        total++; if (sb_empty_o !== 1'b1) begin bad++; $display("[TB] FAIL rnd_final_empty got=%b want=1", sb_empty_o); end
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        @(posedge clk);
        #1;
        test_reset();
        test_byte_store();
        test_half_and_misalign();
        test_back_to_back();
        test_ld_hit();
        test_flush_illegal();
        test_reset_mid_request();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
# store_buffer

Write-side counterpart to the load extraction in the MEM stage: accepts stores from EX, aligns data into byte lanes, and generates byte enables. Accepted stores are queued in an in-order buffer and drained to the data bus over a req/ack handshake, so the pipeline stalls only when the buffer is full. It also reports load-after-store word hazards and buffer-empty status for fences and WFI.

## Interface
- XLEN, 32, data/address width (only 32 supported)
- DEPTH, 2, buffer entries (power of 2, ≥2)

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- st_valid_i  in  1  store request from EX this cycle
- st_addr_i  in  XLEN  byte address
- st_data_i  in  XLEN  rs2 value, unaligned (source in low bits)
- st_mask_i  in  5  size code: [3:0]=0001 byte, 0011 half, 1111 word; bit4 ignored
- flush_i  in  1  discard this cycle's incoming store (buffered entries unaffected)
- st_ready_o  out  1  buffer not full
- st_misalign_o  out  1  incoming store misaligned or illegal size code
- dbus_req_o  out  1  write request valid
- dbus_addr_o  out  XLEN  word-aligned address ([1:0]=00)
- dbus_wdata_o  out  XLEN  lane-aligned write data
- dbus_be_o  out  4  byte enables
- dbus_ack_i  in  1  bus accepts the current request
- ld_addr_i  in  XLEN  address of load in EX/MEM
- ld_hit_o  out  1  load word address matches a buffered store
- sb_empty_o  out  1  buffer empty and no request outstanding

## Operation
- Accept = st_valid_i & st_ready_o & !st_misalign_o & !flush_i. An accepted store is written at the tail on that edge.
- Misalignment:
  - Half: addr[0]≠0 is misaligned.
  - Word: addr[1:0]≠00 is misaligned.
  - Any other [3:0] code is illegal.
  - st_misalign_o = st_valid_i & (misaligned | illegal), combinational. A flagged store is never queued; EX raises the exception.
- Lane alignment is done at enqueue (k = addr[1:0]):
  - Byte: wdata={4{d[7:0]}}, be=0001<<k.
  - Half: wdata={2{d[15:0]}}, be=0011<<(2·addr[1]).
  - Word: wdata=d, be=1111.
  - Entry address is {addr[XLEN-1:2],2'b00}.
- FSM, states IDLE and REQ:
  - IDLE → REQ when the buffer is non-empty after the current edge.
  - In REQ, dbus_ack_i pops the head. The FSM stays in REQ if entries remain after the pop (including one enqueued that cycle); otherwise it goes to IDLE.
  - dbus_req_o = (state==REQ).
- dbus_addr_o, dbus_wdata_o and dbus_be_o come from the head entry's registers. They are stable while dbus_req_o is high and ack is low.
- Drain order is strictly FIFO. No merging.
- st_ready_o = count<DEPTH. A pop in the same cycle does not free space for that cycle's store (no bypass).
- ld_hit_o: combinational compare of ld_addr_i[XLEN-1:2] against every valid entry, including the head being acked this cycle. The incoming same-cycle store is not compared.
- sb_empty_o = (count==0) & (state==IDLE).
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits. Simultaneous enqueue and pop leaves count unchanged.

## Timing
- Reset values: state=IDLE, count=0, pointers=0, entries=0.
- Outputs during and after reset: dbus_req_o=0, dbus_addr_o/wdata_o/be_o=0, st_ready_o=1, sb_empty_o=1, ld_hit_o=0. st_misalign_o depends only on inputs.
- Latency: a store accepted in cycle N into an empty buffer gives dbus_req_o=1 in cycle N+1.
- Ack in cycle M with more entries queued: the next entry is presented in M+1 with req held high. Sustained throughput is 1 store/cycle.
- Ack while req=0 is ignored.
- rst mid-request: req drops the next cycle and all buffered stores are lost (reset is fatal).
- flush_i does not cancel an outstanding request or any buffered entry.

## Test plan
- sb, addr 0x0000_1003, data 0x1122_33A5 → cycle N+1: req=1, addr 0x0000_1000, wdata 0xA5A5_A5A5, be 1000; ack → sb_empty_o=1 the next cycle.
- sh, addr 0x0000_2002, data 0x1234_BEEF → wdata 0xBEEF_BEEF, be 1100. Then sw at 0x0000_3001 → st_misalign_o=1, nothing queued, req stays 0.
- Two sw (0x10→0xAAAA_AAAA, 0x14→0xBBBB_BBBB) with ack held 0 → st_ready_o=0 and a third store is refused. Then ack every cycle → 0x10 then 0x14 drained in consecutive cycles with req continuously high, and the third store is accepted once count<2.
- Queue sw at 0x40, ld_addr_i=0x42 → ld_hit_o=1; ld_addr_i=0x44 → 0. After ack drains it → ld_hit_o=0.
- Store with flush_i=1 → not queued, sb_empty_o stays 1. Store with st_mask_i=0b00111 → misalign=1.
- rst asserted while req=1 with 2 entries → the next cycle req=0, st_ready_o=1, sb_empty_o=1.
